// File: rtl/complex_fir_serial.sv
// complex_fir_serial: time-multiplexed complex FIR, one complex MAC per clock,
// rounded and saturated output per accepted sample with valid/ready handshakes.
module complex_fir_serial #(
  parameter int NTAPS = 32,
  parameter int DW    = 18,
  parameter int CW    = 18,
  parameter int OW    = 18,
  parameter int SHIFT = 17,
  parameter int ACCW  = DW + CW + 1 + $clog2(NTAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]  coef_real,
  input  logic signed [CW-1:0]  coef_imag,
  output logic                  coef_busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DW-1:0]  in_real,
  input  logic signed [DW-1:0]  in_imag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [OW-1:0]  out_real,
  output logic signed [OW-1:0]  out_imag,
  output logic                  out_ovf
);
  localparam int AW = $clog2(NTAPS);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  localparam logic [AW:0] NT = (AW + 1)'(NTAPS);
  localparam logic [ACCW:0] ONE_SH = {{ACCW{1'b0}}, 1'b1} << SHIFT;
  localparam logic signed [ACCW-1:0] RND = ONE_SH[ACCW:1];
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, base_q, base_d, k_q, k_d, rd_idx;
  logic signed [ACCW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [OW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic ovf_q, ovf_d;
  logic signed [CW-1:0] cre_q [NTAPS];
  logic signed [CW-1:0] cim_q [NTAPS];
  logic signed [DW-1:0] xre_q [NTAPS];
  logic signed [DW-1:0] xim_q [NTAPS];
  logic signed [ACCW-1:0] cr, ci, xr, xi;
  logic [OW:0] rs_re, rs_im;
  logic coef_wr, smp_wr;

  // Round half up, then clip; bit OW flags a clip.
  function automatic logic [OW:0] rnd_sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] r;
    r = (a + RND) >>> SHIFT;
    return {(r > MAXV) || (r < MINV),
            (r > MAXV) ? MAXV[OW-1:0] : (r < MINV) ? MINV[OW-1:0] : r[OW-1:0]};
  endfunction

  assign rd_idx = (base_q >= k_q) ? base_q - k_q : base_q - k_q + NT[AW-1:0];
  assign cr = ACCW'(cre_q[k_q]);
  assign ci = ACCW'(cim_q[k_q]);
  assign xr = ACCW'(xre_q[rd_idx]);
  assign xi = ACCW'(xim_q[rd_idx]);
  assign rs_re = rnd_sat(acc_re_q);
  assign rs_im = rnd_sat(acc_im_q);
  assign coef_wr = coef_we && (state_q == IDLE) && (coef_addr <= LAST);
  assign smp_wr = in_valid && (state_q == IDLE);

  assign coef_busy = state_q != IDLE;
  assign in_ready  = (state_q == IDLE) && reset;
  assign out_valid = state_q == OUT;
  assign out_real  = out_re_q;
  assign out_imag  = out_im_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    base_d   = base_q;
    k_d      = k_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = MAC;
        base_d   = wp_q;
        wp_d     = (wp_q == LAST) ? '0 : wp_q + AW'(1);
        k_d      = '0;
        acc_re_d = '0;
        acc_im_d = '0;
      end
      MAC: begin
        acc_re_d = acc_re_q + cr * xr - ci * xi;
        acc_im_d = acc_im_q + cr * xi + ci * xr;
        k_d      = (k_q == LAST) ? '0 : k_q + AW'(1);
        state_d  = (k_q == LAST) ? ROUND : MAC;
      end
      ROUND: begin
        out_re_d = rs_re[OW-1:0];
        out_im_d = rs_im[OW-1:0];
        ovf_d    = rs_re[OW] | rs_im[OW];
        state_d  = OUT;
      end
      OUT: state_d = out_ready ? IDLE : OUT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wp_q     <= '0;
      base_q   <= '0;
      k_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        cre_q[i] <= '0;
        cim_q[i] <= '0;
        xre_q[i] <= '0;
        xim_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      base_q   <= base_d;
      k_q      <= k_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      ovf_q    <= ovf_d;
      if (coef_wr) begin
        cre_q[coef_addr] <= coef_real;
        cim_q[coef_addr] <= coef_imag;
      end
      if (smp_wr) begin
        xre_q[wp_q] <= in_real;
        xim_q[wp_q] <= in_imag;
      end
    end
  end
endmodule

// File: tb/tb_complex_fir_serial.sv
// tb_complex_fir_serial: scoreboard bench driving SHIFT=0 and SHIFT=17 instances
// in lockstep from a reference convolution model.
module tb_complex_fir_serial;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic coef_we = 1'b0;
  logic [4:0] coef_addr = '0;
  logic signed [17:0] coef_real = '0, coef_imag = '0, in_real = '0, in_imag = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic busy0, rdy0, ov0, ovf0, busy17, rdy17, ov17, ovf17;
  logic signed [17:0] ore0, oim0, ore17, oim17;

  typedef struct {longint r0, i0, r17, i17; bit o0, o17;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  longint mcr[32], mci[32], mxr[32], mxi[32];
  int mwp = 0;
  int n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  complex_fir_serial #(.SHIFT(0)) u_s0 (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_real(coef_real), .coef_imag(coef_imag), .coef_busy(busy0),
    .in_valid(in_valid), .in_ready(rdy0), .in_real(in_real), .in_imag(in_imag),
    .out_valid(ov0), .out_ready(out_ready), .out_real(ore0), .out_imag(oim0),
    .out_ovf(ovf0));

  complex_fir_serial #(.SHIFT(17)) u_s17 (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_real(coef_real), .coef_imag(coef_imag), .coef_busy(busy17),
    .in_valid(in_valid), .in_ready(rdy17), .in_real(in_real), .in_imag(in_imag),
    .out_valid(ov17), .out_ready(out_ready), .out_real(ore17), .out_imag(oim17),
    .out_ovf(ovf17));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void rs(input longint a, input int sh, output longint v, output bit o);
    longint r;
    r = (sh > 0) ? ((a + (64'sd1 <<< (sh - 1))) >>> sh) : a;
    o = (r > 131071) || (r < -131072);
    v = (r > 131071) ? 131071 : (r < -131072) ? -131072 : r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      mcr[i] = 0; mci[i] = 0; mxr[i] = 0; mxi[i] = 0;
    end
    mwp = 0;
  endfunction

  always @(negedge clk) begin
    if (reset && ov0 && out_ready) begin
      check("sb_pending", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("real_s0", ore0, mon_e.r0);
        check("imag_s0", oim0, mon_e.i0);
        check("ovf_s0", ovf0, mon_e.o0);
        check("valid_s17", ov17, 1);
        check("real_s17", ore17, mon_e.r17);
        check("imag_s17", oim17, mon_e.i17);
        check("ovf_s17", ovf17, mon_e.o17);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    sb.delete();
    @(posedge clk); #1;
    check("rst_in_ready", rdy0, 0);
    check("rst_out_valid", ov0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("idle_in_ready", rdy0, 1);
    check("idle_busy", busy0, 0);
  endtask

  task automatic wr_coef(input int k, input longint re, input longint im, input bit upd);
    coef_we = 1'b1;
    coef_addr = 5'(k);
    coef_real = 18'(re);
    coef_imag = 18'(im);
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (upd) begin
      mcr[k] = re;
      mci[k] = im;
    end
  endtask

  task automatic send(input longint re, input longint im);
    exp_t e;
    longint ar, ai;
    bit oa, ob;
    int n, idx;
    in_valid = 1'b1;
    in_real = 18'(re);
    in_imag = 18'(im);
    n = 0;
    while (!rdy0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready", rdy0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mxr[mwp] = re;
    mxi[mwp] = im;
    ar = 0;
    ai = 0;
    for (int k = 0; k < 32; k++) begin
      idx = (mwp - k + 32) % 32;
      ar += mcr[k] * mxr[idx] - mci[k] * mxi[idx];
      ai += mcr[k] * mxi[idx] + mci[k] * mxr[idx];
    end
    mwp = (mwp + 1) % 32;
    rs(ar, 0, e.r0, oa);
    rs(ai, 0, e.i0, ob);
    e.o0 = oa | ob;
    rs(ar, 17, e.r17, oa);
    rs(ai, 17, e.i17, ob);
    e.o17 = oa | ob;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int lat, seen;
    // impulse through tap 0 at unity gain (SHIFT=17) plus latency
    do_reset();
    wr_coef(0, 131071, 0, 1);
    send(1000, -500);
    lat = 0;
    while (!ov0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 33);
    drain();
    check("t1_real17", ore17, 1000);
    check("t1_imag17", oim17, -500);
    check("t1_ovf17", ovf17, 0);
    // ramp coefficients, impulse then zeros exercises wrap
    do_reset();
    for (int k = 0; k < 32; k++) wr_coef(k, k, -k, 1);
    send(1000, 0);
    drain();
    for (int i = 0; i < 35; i++) begin
      send(0, 0);
      drain();
    end
    check("t2_last_real", ore0, 0);
    check("t2_last_imag", oim0, 0);
    // single complex product
    do_reset();
    wr_coef(0, 3, 4, 1);
    send(5, 6);
    drain();
    check("t3_real", ore0, -9);
    check("t3_imag", oim0, 38);
    // saturation both directions
    do_reset();
    for (int k = 0; k < 32; k++) wr_coef(k, 131071, 0, 1);
    for (int i = 0; i < 32; i++) begin
      send(131071, 0);
      drain();
    end
    check("t4_pos_real", ore0, 131071);
    check("t4_pos_ovf", ovf0, 1);
    for (int i = 0; i < 32; i++) begin
      send(-131072, 0);
      drain();
    end
    check("t4_neg_real", ore0, -131072);
    check("t4_neg_ovf", ovf0, 1);
    // backpressure
    out_ready = 1'b0;
    send(1, 1);
    lat = 0;
    while (!ov0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_rise", ov0, 1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", ov0, 1);
      check("bp_real", ore0, sb[0].r0);
      check("bp_imag", oim0, sb[0].i0);
      check("bp_in_ready", rdy0, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_in_ready_after", rdy0, 1);
    check("bp_valid_after", ov0, 0);
    check("bp_sb", sb.size(), 0);
    out_ready = 1'b1;
    // coefficient write while busy is dropped
    do_reset();
    wr_coef(0, 7, 2, 1);
    send(1, 0);
    check("busy_mac", busy0, 1);
    wr_coef(0, 999, 999, 0);
    drain();
    send(1, 0);
    drain();
    check("drop_real", ore0, 7);
    check("drop_imag", oim0, 2);
    // reset mid-MAC aborts the result
    send(5, 5);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_in_ready", rdy0, 0);
    check("abort_valid", ov0, 0);
    check("abort_real", ore0, 0);
    check("abort_imag", oim0, 0);
    check("abort_ovf", ovf0, 0);
    check("abort_busy", busy0, 0);
    check("abort_real17", ore17, 0);
    sb.delete();
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov0) seen++;
    end
    check("abort_no_out", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/complex_fir_serial.md
Name: complex_fir_serial

Overview:
- Parametrised, time-multiplexed complex FIR convolver; the next generation of the fixed 32-tap, 18-bit complex convolver used in the fader datapath.
- Holds NTAPS complex coefficients in a write port, plus an NTAPS-deep complex sample delay line.
- One complex MAC per clock; valid/ready handshakes on both sample ports.
- Produces one rounded, saturated complex output per accepted input sample.

Parameters:
NTAPS, 32, number of taps (>=2)
DW, 18, input sample width per component, signed
CW, 18, coefficient width per component, signed
OW, 18, output width per component, signed
SHIFT, 17, right-shift applied to the accumulator before output (0..ACCW-OW)
ACCW, DW+CW+1+$clog2(NTAPS), accumulator width (derived, do not override)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(NTAPS)  tap index for write
coef_real  in  CW  coefficient real part
coef_imag  in  CW  coefficient imaginary part
coef_busy  out  1  high while a convolution is in progress; writes are ignored
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_real  in  DW  sample real part
in_imag  in  DW  sample imaginary part
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_real  out  OW  result real part
out_imag  out  OW  result imaginary part
out_ovf  out  1  saturation occurred on this result (either component)

Behaviour:
- Reset (reset=0, async): state=IDLE; all coefficients, delay-line entries, accumulators, pointers and counters = 0. Outputs: in_ready=0 during reset, then 1 in IDLE; out_valid=0, out_real=0, out_imag=0, out_ovf=0, coef_busy=0.
- Coefficient write: when coef_we=1 and state==IDLE, c[coef_addr] <= {coef_real, coef_imag} at the clock edge. When state!=IDLE, the write is dropped with no effect. A write on the same edge as a sample acceptance takes effect and applies to that sample.
- State machine: IDLE -> MAC -> ROUND -> OUT -> IDLE.
  - IDLE: in_ready=1. On in_valid&in_ready: x[wp] <= sample; latch base=wp; wp <= (wp+1) mod NTAPS; k <= 0; acc <= 0; go to MAC.
  - MAC: NTAPS cycles, k = 0..NTAPS-1. Each cycle, with xs = x[(base-k) mod NTAPS] and c = c[k]:
    - acc_re += c_re*xs_re - c_im*xs_im
    - acc_im += c_re*xs_im + c_im*xs_re
    - Combinational products, full ACCW precision, no intermediate overflow.
    - After k==NTAPS-1, go to ROUND.
  - ROUND: one cycle. For each component, r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT (round half up). Saturate r to [-2^(OW-1), 2^(OW-1)-1]. out_ovf = OR of both components' clip flags. Register results; go to OUT.
  - OUT: out_valid=1. out_real, out_imag and out_ovf are held stable until out_valid&out_ready; then out_valid <= 0 and go to IDLE.
- coef_busy = (state != IDLE). in_ready = (state == IDLE) and not in reset.
- Latency: with the sample accepted at edge E0, out_valid rises after edge E0+NTAPS+1. Throughput is one sample per NTAPS+3 cycles when out_ready is held high.
- The delay line is zero after reset, so the first NTAPS-1 outputs see zero history.
- Pointer wrap: wp and (base-k) wrap modulo NTAPS; NTAPS need not be a power of two.
- out_real and out_imag retain their last value when out_valid=0.
- Reset asserted mid-MAC or mid-OUT aborts the operation: the result is lost and all state returns to reset values.

Test Plan:
- NTAPS=32, SHIFT=17; write c[0]=(131071,0), other taps 0; send x=(1000,-500) -> after 33 cycles out=(1000,-500), out_ovf=0.
- SHIFT=0; c[k]=(k,-k) for k=0..31; send (1000,0) followed by 35 samples of (0,0) -> outputs n=0..31 equal (1000n,-1000n); outputs n>=32 equal (0,0).
- SHIFT=0; c[0]=(3,4), x=(5,6) -> out=(-9,38).
- SHIFT=0, OW=18; all c=(131071,0); 32 samples of (131071,0) -> the 32nd output is (131071,0) with out_ovf=1. Repeat with (-131072,0) -> (-131072,0), out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and data stay stable and in_ready=0 throughout. Then pulse out_ready -> one transfer, and in_ready=1 on the next cycle.
- Pulse coef_we during MAC -> the coefficient is unchanged (read back via an impulse test). Assert reset at MAC cycle 10 -> out_valid never rises, and all outputs return to reset values immediately.
